// File: rtl/lr_d_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// lr_d_sequencer_pkg
//   Shared definitions for the leaky-ReLU-derivative row sequencer.
//   - LR_D_DATA_W : fixed-point data width used by the lanes (Q-format 16 bit)
//   - lr_d_state_t: sequencer FSM state, also exported on the debug port
// ---------------------------------------------------------------------------
package lr_d_sequencer_pkg;

    localparam int LR_D_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } lr_d_state_t;

endpackage

// File: rtl/lr_d_sequencer_skew.sv
// ---------------------------------------------------------------------------
// lr_d_skew_shift
//   Registered shift chain that staggers the lane-0 valid across the lanes.
//   o_valid[0] is i_valid itself; o_valid[i] is i_valid delayed by i cycles.
//   The chain always shifts, independent of any stall, so rows already in
//   flight keep walking towards the last lane.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, clears the whole chain
//   i_valid  : lane-0 valid
//   o_valid  : per-lane valid, LANES bits
// ---------------------------------------------------------------------------
module lr_d_skew_shift #(
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic [LANES-1:0] o_valid
);

    generate
        if (LANES == 1) begin : g_single
            assign o_valid = i_valid;
        end else begin : g_chain
            logic [LANES-2:0] r_chain;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_chain <= '0;
                end else begin
                    r_chain[0] <= i_valid;
                    for (int k = 1; k < LANES - 1; k++) begin
                        r_chain[k] <= r_chain[k-1];
                    end
                end
            end

            assign o_valid = {r_chain, i_valid};
        end
    endgenerate

endmodule

// File: rtl/lr_d_sequencer.sv
// ---------------------------------------------------------------------------
// lr_d_sequencer
//   Issues one H-cache row per cycle to a bank of leaky_relu_derivative lanes.
//   A job is started from IDLE; rows 0..num_rows-1 are read out in order, the
//   lane-0 valid is skewed across the lanes, and after the last row the FSM
//   waits LANES cycles (skew plus child output latency) before pulsing done.
//
// Handshake: lr_d_start is a single-cycle request honoured only in IDLE;
//   lr_d_stall is a level hold that suppresses row issue in RUN for every
//   cycle it is high, the row is then issued on the first unstalled cycle.
//
// Ports
//   clk, rst              : clock (rising edge), async active-high reset
//   lr_d_start            : job start request
//   lr_d_num_rows         : rows in the job, captured on accepted start
//   lr_d_leak_factor_in   : leak factor, captured on accepted start
//   lr_d_stall            : downstream hold
//   lr_d_lane_valid       : per-lane valid, lane i delayed i cycles
//   lr_d_leak_factor_out  : latched leak factor broadcast to the lanes
//   lr_d_h_rd_en          : H-cache read enable
//   lr_d_h_rd_addr        : H-cache row address
//   lr_d_busy             : high from accepted start until done
//   lr_d_done             : one-cycle job complete pulse
//   lr_d_state_dbg        : current FSM state
// ---------------------------------------------------------------------------
module lr_d_sequencer
    import lr_d_sequencer_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ROW_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          lr_d_start,
    input  logic [ROW_W-1:0]              lr_d_num_rows,
    input  logic signed [LR_D_DATA_W-1:0] lr_d_leak_factor_in,
    input  logic                          lr_d_stall,
    output logic [LANES-1:0]              lr_d_lane_valid,
    output logic signed [LR_D_DATA_W-1:0] lr_d_leak_factor_out,
    output logic                          lr_d_h_rd_en,
    output logic [ROW_W-1:0]              lr_d_h_rd_addr,
    output logic                          lr_d_busy,
    output logic                          lr_d_done,
    output lr_d_state_t                   lr_d_state_dbg
);

    // Wide enough to hold LANES-1 for any LANES >= 1.
    localparam int DRAIN_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(LANES - 1);

    lr_d_state_t                   r_state;
    lr_d_state_t                   w_state_nxt;
    logic [ROW_W-1:0]              r_num_rows;
    logic [ROW_W-1:0]              r_row_cnt;
    logic signed [LR_D_DATA_W-1:0] r_leak;
    logic [DRAIN_W-1:0]            r_drain_cnt;

    logic                          w_accept;
    logic                          w_issue;
    logic [ROW_W-1:0]              w_last_row;

    // Only used while in RUN, where r_num_rows is known to be non-zero.
    assign w_last_row = r_num_rows - ROW_W'(1);

    // ------------------------------------------------------------------
    // FSM next state and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (lr_d_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (lr_d_num_rows == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lr_d_stall) begin
                    w_issue = 1'b1;
                    if (r_row_cnt == w_last_row) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Job registers and row counter. The counter steps past the last row
    // index (to num_rows), which never exceeds 2^ROW_W-1, so it cannot wrap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_rows <= '0;
            r_row_cnt  <= '0;
            r_leak     <= '0;
        end else if (w_accept) begin
            r_num_rows <= lr_d_num_rows;
            r_row_cnt  <= '0;
            r_leak     <= lr_d_leak_factor_in;
        end else if (w_issue) begin
            r_row_cnt  <= r_row_cnt + ROW_W'(1);
        end
    end

    // Counts cycles spent in DRAIN; held at zero everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
        end else begin
            r_drain_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Lane skew
    // ------------------------------------------------------------------
    lr_d_skew_shift #(
        .LANES (LANES)
    ) u_skew (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_issue),
        .o_valid (lr_d_lane_valid)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign lr_d_h_rd_en         = w_issue;
    assign lr_d_h_rd_addr       = r_row_cnt;
    assign lr_d_leak_factor_out = r_leak;
    assign lr_d_busy            = (r_state != ST_IDLE);
    assign lr_d_done            = (r_state == ST_DONE);
    assign lr_d_state_dbg       = r_state;

endmodule

// File: tb/tb_lr_d_sequencer.sv
module tb_lr_d_sequencer;
  import lr_d_sequencer_pkg::*;

  localparam int LANES = 4;
  localparam int ROW_W = 8;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [ROW_W-1:0]        num_rows;
  logic signed [15:0]      leak_in;
  logic                    stall;
  logic [LANES-1:0]        lane_valid;
  logic signed [15:0]      leak_out;
  logic                    h_rd_en;
  logic [ROW_W-1:0]        h_rd_addr;
  logic                    busy;
  logic                    done;
  lr_d_state_t             state_dbg;

  always #5 clk = ~clk;

  lr_d_sequencer #(
    .LANES (LANES),
    .ROW_W (ROW_W)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .lr_d_start           (start),
    .lr_d_num_rows        (num_rows),
    .lr_d_leak_factor_in  (leak_in),
    .lr_d_stall           (stall),
    .lr_d_lane_valid      (lane_valid),
    .lr_d_leak_factor_out (leak_out),
    .lr_d_h_rd_en         (h_rd_en),
    .lr_d_h_rd_addr       (h_rd_addr),
    .lr_d_busy            (busy),
    .lr_d_done            (done),
    .lr_d_state_dbg       (state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts a job, then for cycles 1..n_cyc applies stall/start patterns and
  // checks all outputs against the hand-written lane-0 pattern. Lane i is the
  // lane-0 pattern delayed by i cycles; addresses count up over issued rows.
  task automatic run_check(input string tag, input logic [ROW_W-1:0] rows,
                           input logic [15:0] leak, input int n_cyc, input int done_cyc,
                           input logic [63:0] l0_pat, input logic [63:0] stall_pat,
                           input logic [63:0] start_pat);
    int exp_addr;
    logic [LANES-1:0] exp_lanes;
    start    = 1'b1;
    num_rows = rows;
    leak_in  = leak;
    tick();
    start    = 1'b0;
    exp_addr = 0;
    for (int c = 1; c <= n_cyc; c++) begin
      stall = stall_pat[c];
      if (start_pat[c]) begin
        start    = 1'b1;
        num_rows = 8'd9;
        leak_in  = 16'h7FFF;
      end else begin
        start    = 1'b0;
      end
      #1;
      for (int i = 0; i < LANES; i++) begin
        exp_lanes[i] = (c - i >= 1) ? l0_pat[c-i] : 1'b0;
      end
      chk({tag, "_lanes"}, 32'(lane_valid), 32'(exp_lanes));
      chk({tag, "_rd_en"}, 32'(h_rd_en), 32'(l0_pat[c]));
      if (l0_pat[c]) begin
        chk({tag, "_addr"}, 32'(h_rd_addr), 32'(exp_addr));
        exp_addr++;
      end
      chk({tag, "_busy"}, 32'(busy), 32'(c <= done_cyc));
      chk({tag, "_done"}, 32'(done), 32'(c == done_cyc));
      chk({tag, "_leak"}, {16'h0, leak_out}, {16'h0, leak});
      tick();
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int n_valid;
    int n_done;
    logic [LANES-1:0] exp_lanes;

    rst      = 1'b1;
    start    = 1'b0;
    stall    = 1'b0;
    num_rows = '0;
    leak_in  = '0;
    #1;
    chk("rst_lanes", 32'(lane_valid), 32'(0));
    chk("rst_busy",  32'(busy),       32'(0));
    chk("rst_done",  32'(done),       32'(0));
    chk("rst_rd_en", 32'(h_rd_en),    32'(0));
    chk("rst_addr",  32'(h_rd_addr),  32'(0));
    chk("rst_leak",  {16'h0, leak_out}, 32'(0));
    chk("rst_state", 32'(state_dbg),  32'(ST_IDLE));
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'(0));

    // Basic job: rows 1..3 on lane 0, done at cycle 8.
    run_check("basic", 8'd3, 16'h0080, 9, 8, 64'h000E, 64'h0, 64'h0);

    // Empty job: done one cycle after accept, no rows.
    run_check("empty", 8'd0, 16'h0100, 3, 1, 64'h0, 64'h0, 64'h0);

    // Stall cycles 3,4 after row 1: rows issue in cycles 1,2,5,6.
    run_check("stall", 8'd4, 16'h0040, 12, 11, 64'h0066, 64'h0018, 64'h0);

    // Start requests in RUN, DRAIN and DONE are all ignored.
    run_check("busy_start", 8'd2, 16'h1234, 8, 7, 64'h0006, 64'h0, 64'h0092);

    // Reset in the middle of DRAIN.
    start    = 1'b1;
    num_rows = 8'd3;
    leak_in  = 16'h0055;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    chk("pre_rst_lanes", 32'(lane_valid), 32'(4'b1100));
    chk("pre_rst_state", 32'(state_dbg),  32'(ST_DRAIN));
    rst = 1'b1;
    #1;
    chk("mid_rst_lanes", 32'(lane_valid), 32'(0));
    chk("mid_rst_busy",  32'(busy),       32'(0));
    chk("mid_rst_done",  32'(done),       32'(0));
    chk("mid_rst_rd_en", 32'(h_rd_en),    32'(0));
    chk("mid_rst_addr",  32'(h_rd_addr),  32'(0));
    chk("mid_rst_leak",  {16'h0, leak_out}, 32'(0));
    chk("mid_rst_state", 32'(state_dbg),  32'(ST_IDLE));
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("post_rst_done",  32'(done),       32'(0));
      chk("post_rst_busy",  32'(busy),       32'(0));
      chk("post_rst_lanes", 32'(lane_valid), 32'(0));
      tick();
    end
    run_check("after_rst", 8'd3, 16'h0080, 9, 8, 64'h000E, 64'h0, 64'h0);

    // Maximum row count: 255 rows, drain 256..259, done at 260.
    start    = 1'b1;
    num_rows = 8'd255;
    leak_in  = 16'hFF80;
    tick();
    start   = 1'b0;
    n_valid = 0;
    n_done  = 0;
    for (int c = 1; c <= 262; c++) begin
      for (int i = 0; i < LANES; i++) begin
        exp_lanes[i] = (c - i >= 1) && (c - i <= 255);
      end
      chk("max_lanes", 32'(lane_valid), 32'(exp_lanes));
      chk("max_rd_en", 32'(h_rd_en),    32'(c <= 255));
      if (h_rd_en) begin
        chk("max_addr", 32'(h_rd_addr), 32'(c - 1));
        n_valid++;
      end
      if (done) n_done++;
      chk("max_done", 32'(done), 32'(c == 260));
      chk("max_busy", 32'(busy), 32'(c <= 260));
      chk("max_leak", {16'h0, leak_out}, 32'h0000FF80);
      tick();
    end
    chk("max_valid_count", 32'(n_valid), 32'(255));
    chk("max_done_count",  32'(n_done),  32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
